// File: rtl/rr_priority_encoder.sv
// Registered request encoder: picks one request (round-robin or fixed priority),
// presents it as binary and one-hot under a valid/ready handshake, plus a popcount.
module rr_priority_encoder #(
  parameter int unsigned N_REQ = 8,
  parameter bit          RR_EN = 1'b1,
  localparam int unsigned IDX_W = $clog2(N_REQ),
  localparam int unsigned CNT_W = $clog2(N_REQ + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [CNT_W-1:0] req_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] ptr_adv;
  logic [IDX_W-1:0] arb_ptr;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] pop;
  logic             any_req;

  assign any_req = |req;

  // Pointer after a handshake wraps at N_REQ-1, not at the index width
  always_comb begin
    ptr_adv = '0;
    if (RR_EN) begin
      ptr_adv = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign arb_ptr = (state_q == GRANT) ? ptr_adv : ptr_q;

  // First set bit searching arb_ptr, arb_ptr+1, ... modulo N_REQ
  always_comb begin
    int unsigned pos;
    logic        found;
    logic [N_REQ-1:0] req_sh;
    win    = '0;
    found  = 1'b0;
    pos    = 0;
    req_sh = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(arb_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      req_sh = req >> pos;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = sum + 32'(req[i]);
    end
    pop = CNT_W'(sum);
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = win;
          onehot_d = N_REQ'(1) << win;
          cnt_d    = pop;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d = ptr_adv;
          if (any_req) begin
            idx_d    = win;
            onehot_d = N_REQ'(1) << win;
            cnt_d    = pop;
          end else begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign req_count    = cnt_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> ($onehot(grant_onehot) && (grant_onehot == (N_REQ'(1) << grant_idx))));

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder: three instances (N=8 RR, N=5 RR, N=8 fixed)
// checked against a cycle-level behavioural model plus directed expectations.
module tb_rr_priority_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req8 = 8'h00;  logic rdy8 = 1'b0;
  logic [4:0] req5 = 5'h00;  logic rdy5 = 1'b0;
  logic [7:0] reqf = 8'h00;  logic rdyf = 1'b0;

  logic g8_valid; logic [2:0] g8_idx; logic [7:0] g8_oh; logic [3:0] g8_cnt;
  logic g5_valid; logic [2:0] g5_idx; logic [4:0] g5_oh; logic [2:0] g5_cnt;
  logic gf_valid; logic [2:0] gf_idx; logic [7:0] gf_oh; logic [3:0] gf_cnt;

  rr_priority_encoder #(.N_REQ(8), .RR_EN(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .grant_ready(rdy8),
    .grant_valid(g8_valid), .grant_idx(g8_idx), .grant_onehot(g8_oh), .req_count(g8_cnt));

  rr_priority_encoder #(.N_REQ(5), .RR_EN(1'b1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .grant_ready(rdy5),
    .grant_valid(g5_valid), .grant_idx(g5_idx), .grant_onehot(g5_oh), .req_count(g5_cnt));

  rr_priority_encoder #(.N_REQ(8), .RR_EN(1'b0)) u_dutf (
    .clk(clk), .rst_n(rst_n), .req(reqf), .grant_ready(rdyf),
    .grant_valid(gf_valid), .grant_idx(gf_idx), .grant_onehot(gf_oh), .req_count(gf_cnt));

  int tests = 0;
  int fails = 0;

  // Behavioural model state per instance: 0 = N8 RR, 1 = N5 RR, 2 = N8 fixed
  bit m_valid[3];
  int m_idx[3];
  int m_cnt[3];
  int m_ptr[3];

  function automatic int win(int r, int p, int n);
    for (int k = 0; k < n; k++) begin
      int j = (p + k) % n;
      if (((r >> j) & 1) != 0) return j;
    end
    return 0;
  endfunction

  function automatic int pop(int r);
    int c = 0;
    for (int k = 0; k < 32; k++) c += (r >> k) & 1;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0; m_idx[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end
  endfunction

  // Expected / observed packed views; idx and count are don't-care while invalid
  function automatic logic [15:0] exp8();
    return {m_valid[0], m_valid[0] ? 3'(m_idx[0]) : 3'b0,
            m_valid[0] ? 8'(1 << m_idx[0]) : 8'h00, m_valid[0] ? 4'(m_cnt[0]) : 4'h0};
  endfunction
  function automatic logic [15:0] obs8();
    return {g8_valid, m_valid[0] ? g8_idx : 3'b0, g8_oh, m_valid[0] ? g8_cnt : 4'h0};
  endfunction
  function automatic logic [11:0] exp5();
    return {m_valid[1], m_valid[1] ? 3'(m_idx[1]) : 3'b0,
            m_valid[1] ? 5'(1 << m_idx[1]) : 5'h00, m_valid[1] ? 3'(m_cnt[1]) : 3'h0};
  endfunction
  function automatic logic [11:0] obs5();
    return {g5_valid, m_valid[1] ? g5_idx : 3'b0, g5_oh, m_valid[1] ? g5_cnt : 3'h0};
  endfunction
  function automatic logic [15:0] expf();
    return {m_valid[2], m_valid[2] ? 3'(m_idx[2]) : 3'b0,
            m_valid[2] ? 8'(1 << m_idx[2]) : 8'h00, m_valid[2] ? 4'(m_cnt[2]) : 4'h0};
  endfunction
  function automatic logic [15:0] obsf();
    return {gf_valid, m_valid[2] ? gf_idx : 3'b0, gf_oh, m_valid[2] ? gf_cnt : 4'h0};
  endfunction

  // One clock: capture inputs, advance the model on the edge, settle
  task automatic tick();
    int r[3];
    bit rd[3];
    int nn[3];
    bit rr[3];
    nn = '{8, 5, 8};
    rr = '{1'b1, 1'b1, 1'b0};
    r[0] = int'(req8); r[1] = int'(req5); r[2] = int'(reqf);
    rd[0] = rdy8; rd[1] = rdy5; rd[2] = rdyf;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_valid[i]) begin
          if (r[i] != 0) begin
            m_valid[i] = 1'b1;
            m_idx[i] = win(r[i], m_ptr[i], nn[i]);
            m_cnt[i] = pop(r[i]);
          end
        end else if (rd[i]) begin
          if (rr[i]) m_ptr[i] = (m_idx[i] + 1) % nn[i];
          if (r[i] != 0) begin
            m_idx[i] = win(r[i], m_ptr[i], nn[i]);
            m_cnt[i] = pop(r[i]);
          end else begin
            m_valid[i] = 1'b0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    req8 = 8'h00; rdy8 = 1'b0; req5 = 5'h00; rdy5 = 1'b0; reqf = 8'h00; rdyf = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req8 = 8'hFF; rdy8 = 1'b1;
    model_reset();
    #12;
    tests++;
    if ({g8_valid, g8_oh, g8_cnt} !== 13'h0) begin
      fails++;
      $display("FAIL reset_hold: got valid=%0b oh=%h cnt=%0d, want 0/00/0", g8_valid, g8_oh, g8_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({g8_valid, g8_idx, g8_oh, g8_cnt} !== {1'b1, 3'd0, 8'h01, 4'd8}) begin
      fails++;
      $display("FAIL reset_first_grant: got v=%0b idx=%0d oh=%h cnt=%0d, want 1/0/01/8",
               g8_valid, g8_idx, g8_oh, g8_cnt);
    end
  endtask

  task automatic test_rr_sweep();
    for (int k = 1; k <= 9; k++) begin
      tick();
      tests++;
      if ({g8_valid, g8_idx, g8_oh} !== {1'b1, 3'(k % 8), 8'(1 << (k % 8))} || obs8() !== exp8()) begin
        fails++;
        $display("FAIL rr_sweep[%0d]: got v=%0b idx=%0d oh=%h, want 1/%0d", k, g8_valid, g8_idx, g8_oh, k % 8);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req8 = 8'h24; rdy8 = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({g8_valid, g8_idx, g8_oh, g8_cnt} !== {1'b1, 3'd2, 8'h04, 4'd2}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%0b idx=%0d oh=%h cnt=%0d, want 1/2/04/2",
                 k, g8_valid, g8_idx, g8_oh, g8_cnt);
      end
      if (k == 1) req8 = 8'h80;
      tick();
    end
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    tests++;
    if ({g8_valid, g8_idx, g8_oh, g8_cnt} !== {1'b1, 3'd7, 8'h80, 4'd1} || obs8() !== exp8()) begin
      fails++;
      $display("FAIL bp_release: got v=%0b idx=%0d oh=%h cnt=%0d, want 1/7/80/1",
               g8_valid, g8_idx, g8_oh, g8_cnt);
    end
  endtask

  task automatic test_wrap5();
    do_reset();
    req5 = 5'b10001; rdy5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if ({g5_valid, g5_idx} !== {1'b1, (k % 2 == 0) ? 3'd0 : 3'd4} || obs5() !== exp5()) begin
        fails++;
        $display("FAIL wrap5[%0d]: got v=%0b idx=%0d oh=%h, want idx=%0d",
                 k, g5_valid, g5_idx, g5_oh, (k % 2 == 0) ? 0 : 4);
      end
    end
    req5 = 5'h00;
    tick();
    rdy5 = 1'b0;
    tests++;
    if ({g5_valid, g5_oh} !== 6'h00) begin
      fails++;
      $display("FAIL wrap5_drop: got v=%0b oh=%h, want 0/00", g5_valid, g5_oh);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    reqf = 8'hFF; rdyf = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) reqf = 8'hF0;
      tick();
      tests++;
      if ({gf_valid, gf_idx} !== {1'b1, (k < 4) ? 3'd0 : 3'd4} || obsf() !== expf()) begin
        fails++;
        $display("FAIL fixed[%0d]: got v=%0b idx=%0d, want idx=%0d", k, gf_valid, gf_idx, (k < 4) ? 0 : 4);
      end
    end
    reqf = 8'h00;
    tick();
    rdyf = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req8 = 8'h08; rdy8 = 1'b0;
    tick();
    tests++;
    if ({g8_valid, g8_idx} !== {1'b1, 3'd3}) begin
      fails++;
      $display("FAIL areset_pre: got v=%0b idx=%0d, want 1/3", g8_valid, g8_idx);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({g8_valid, g8_idx, g8_oh, g8_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL areset_clear: got v=%0b idx=%0d oh=%h cnt=%0d, want all 0",
               g8_valid, g8_idx, g8_oh, g8_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({g8_valid, g8_idx, g8_oh, g8_cnt} !== {1'b1, 3'd3, 8'h08, 4'd1}) begin
      fails++;
      $display("FAIL areset_reissue: got v=%0b idx=%0d oh=%h cnt=%0d, want 1/3/08/1",
               g8_valid, g8_idx, g8_oh, g8_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req5 = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      reqf = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy8 = ($urandom_range(0, 9) < 6);
      rdy5 = ($urandom_range(0, 9) < 6);
      rdyf = ($urandom_range(0, 9) < 6);
      tick();
      tests++;
      if (obs8() !== exp8()) begin
        fails++;
        $display("FAIL rand_n8[%0d]: got %h want %h", c, obs8(), exp8());
      end
      tests++;
      if (obs5() !== exp5()) begin
        fails++;
        $display("FAIL rand_n5[%0d]: got %h want %h", c, obs5(), exp5());
      end
      tests++;
      if (obsf() !== expf()) begin
        fails++;
        $display("FAIL rand_fixed[%0d]: got %h want %h", c, obsf(), expf());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_backpressure();
    test_wrap5();
    test_fixed();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
